// File: rtl/mips_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// mips_multicycle_ctrl
//
// Main control FSM for the multi-cycle MIPS-32 datapath. It steps each
// instruction through fetch, decode, execute, memory and writeback states. It
// drives the mux selects, the write enables and the 2-bit alu_op used by
// alu_control. The memory states stall on mem_ready from the unified
// instruction/data memory.
//
// Parameters
//   MEM_HANDSHAKE : 1 = memory states wait for mem_ready,
//                   0 = memory is single-cycle and mem_ready is ignored.
//   STATE_W       : width of the debug state output.
//
// Ports
//   clk, reset          : clock and synchronous active-high reset.
//   opcode              : IR[31:26]. Sampled only in DECODE, MEM_ADDR and BRANCH.
//   zero                : ALU zero flag, used for the branch decision.
//   mem_ready           : memory access completes in this cycle.
//   pc_write, pc_src    : PC load enable (branch condition folded in) and source.
//   i_or_d, mem_read,
//   mem_write, ir_write : memory address select, strobes and IR load.
//   reg_dst, mem_to_reg,
//   reg_write           : register file destination, writeback source, enable.
//   alu_src_a/_b,
//   ext_zero, alu_op    : ALU operand selects, immediate extension, ALU op.
//   trap                : illegal-opcode trap indicator.
//   state               : current state encoding, for debug.
//
// Optional feature: define MIPS_CTRL_ILLEGAL_TRAP_EN to build the TRAP state.
// An illegal opcode then parks the FSM in TRAP until reset. Without the macro,
// an illegal opcode acts as a NOP and trap is tied to 0.
// -----------------------------------------------------------------------------
module mips_multicycle_ctrl #(
   parameter int MEM_HANDSHAKE = 1,
   parameter int STATE_W       = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [5:0]         opcode,
   input  logic               zero,
   input  logic               mem_ready,
   output logic               pc_write,
   output logic [1:0]         pc_src,
   output logic               i_or_d,
   output logic               mem_read,
   output logic               mem_write,
   output logic               ir_write,
   output logic               reg_dst,
   output logic               mem_to_reg,
   output logic               reg_write,
   output logic               alu_src_a,
   output logic [1:0]         alu_src_b,
   output logic               ext_zero,
   output logic [1:0]         alu_op,
   output logic               trap,
   output logic [STATE_W-1:0] state
);

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_J     = 6'b000010;

   typedef enum logic [3:0] {
      S_FETCH     = 4'd0,
      S_DECODE    = 4'd1,
      S_MEM_ADDR  = 4'd2,
      S_MEM_READ  = 4'd3,
      S_MEM_WB    = 4'd4,
      S_MEM_WRITE = 4'd5,
      S_EXEC      = 4'd6,
      S_ALU_WB    = 4'd7,
      S_BRANCH    = 4'd8,
      S_JUMP      = 4'd9,
      S_IMM_EXEC  = 4'd10,
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
      S_IMM_WB    = 4'd11,
      S_TRAP      = 4'd12
`else
      S_IMM_WB    = 4'd11
`endif
   } state_t;

   // Moore control word. The three *_wr flags qualify pc_write and ir_write:
   // fetch_wr waits for mem_ready, branch_wr waits for the branch condition,
   // and jump_wr is unconditional.
   typedef struct packed {
      logic       fetch_wr;
      logic       jump_wr;
      logic       branch_wr;
      logic [1:0] pc_src;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic       ext_zero;
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
      logic [1:0] alu_op;
      logic       trap;
`else
      logic [1:0] alu_op;
`endif
   } ctl_t;

   state_t cur_state;
   state_t nxt_state;
   ctl_t   ctl;
   logic   ready;
   logic   br_taken;

   function automatic ctl_t decode_ctl(input state_t s);
      ctl_t c;
      c = '0;
      case (s)
         S_FETCH: begin
            c.mem_read  = 1'b1;
            c.fetch_wr  = 1'b1;
            c.alu_src_b = 2'b01;
         end
         S_DECODE:    c.alu_src_b = 2'b11;
         S_MEM_ADDR: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = 2'b10;
         end
         S_MEM_READ: begin
            c.mem_read = 1'b1;
            c.i_or_d   = 1'b1;
         end
         S_MEM_WB: begin
            c.reg_write  = 1'b1;
            c.mem_to_reg = 1'b1;
         end
         S_MEM_WRITE: begin
            c.mem_write = 1'b1;
            c.i_or_d    = 1'b1;
         end
         S_EXEC: begin
            c.alu_src_a = 1'b1;
            c.alu_op    = 2'b10;
         end
         S_ALU_WB: begin
            c.reg_write = 1'b1;
            c.reg_dst   = 1'b1;
         end
         S_BRANCH: begin
            c.branch_wr = 1'b1;
            c.alu_src_a = 1'b1;
            c.alu_op    = 2'b01;
            c.pc_src    = 2'b01;
         end
         S_JUMP: begin
            c.jump_wr = 1'b1;
            c.pc_src  = 2'b10;
         end
         S_IMM_EXEC: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = 2'b10;
            c.ext_zero  = 1'b1;
            c.alu_op    = 2'b11;
         end
         S_IMM_WB:    c.reg_write = 1'b1;
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
         S_TRAP:      c.trap = 1'b1;
`endif
         default:     c = '0;
      endcase
      return c;
   endfunction

   function automatic state_t next_of(input state_t s, input logic rdy,
                                      input logic [5:0] op);
      state_t n;
      n = S_FETCH;
      case (s)
         S_FETCH: n = rdy ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (op)
               OP_RTYPE:       n = S_EXEC;
               OP_LW, OP_SW:   n = S_MEM_ADDR;
               OP_BEQ, OP_BNE: n = S_BRANCH;
               OP_ORI:         n = S_IMM_EXEC;
               OP_J:           n = S_JUMP;
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
               default:        n = S_TRAP;
`else
               // The PC was already incremented in FETCH, so this is a NOP.
               default:        n = S_FETCH;
`endif
            endcase
         end
         S_MEM_ADDR:  n = (op == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
         S_MEM_READ:  n = rdy ? S_MEM_WB : S_MEM_READ;
         S_MEM_WRITE: n = rdy ? S_FETCH : S_MEM_WRITE;
         S_EXEC:      n = S_ALU_WB;
         S_IMM_EXEC:  n = S_IMM_WB;
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
         S_TRAP:      n = S_TRAP;
`endif
         default:     n = S_FETCH;
      endcase
      return n;
   endfunction

   assign ready     = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;
   assign nxt_state = next_of(cur_state, ready, opcode);

   // The control word is registered from the state being entered. This keeps
   // the outputs a Moore decode of cur_state while still driving them from flops.
   always_ff @(posedge clk) begin
      if (reset) begin
         cur_state <= S_FETCH;
         ctl       <= decode_ctl(S_FETCH);
      end else begin
         cur_state <= nxt_state;
         ctl       <= decode_ctl(nxt_state);
      end
   end

   assign br_taken = ((opcode == OP_BEQ) & zero) | ((opcode == OP_BNE) & ~zero);

   // A fetch write is held off while reset is asserted, so reset wins over a
   // coincident mem_ready.
   assign pc_write   = (ctl.fetch_wr & ready & ~reset) | ctl.jump_wr |
                       (ctl.branch_wr & br_taken);
   assign ir_write   = ctl.fetch_wr & ready & ~reset;
   assign pc_src     = ctl.pc_src;
   assign i_or_d     = ctl.i_or_d;
   assign mem_read   = ctl.mem_read;
   assign mem_write  = ctl.mem_write;
   assign reg_dst    = ctl.reg_dst;
   assign mem_to_reg = ctl.mem_to_reg;
   assign reg_write  = ctl.reg_write;
   assign alu_src_a  = ctl.alu_src_a;
   assign alu_src_b  = ctl.alu_src_b;
   assign ext_zero   = ctl.ext_zero;
   assign alu_op     = ctl.alu_op;
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
   assign trap       = ctl.trap;
`else
   assign trap       = 1'b0;
`endif
   assign state      = STATE_W'(cur_state);

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mips_multicycle_ctrl
//
// Scoreboard bench for mips_multicycle_ctrl. The stimulus process walks each
// instruction through the state sequence implied by its opcode. In every cycle
// it pushes the expected state and control word onto a queue. The monitor pops
// one entry per falling edge and compares it with the DUT outputs.
// -----------------------------------------------------------------------------
module tb_mips_multicycle_ctrl;

   localparam int HS = 1;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BAD   = 6'b111111;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] opcode;
   logic       zero;
   logic       mem_ready;
   logic       pc_write, i_or_d, mem_read, mem_write, ir_write;
   logic       reg_dst, mem_to_reg, reg_write, alu_src_a, ext_zero, trap;
   logic [1:0] pc_src, alu_src_b, alu_op;
   logic [3:0] state;

   always #5 clk = ~clk;

   mips_multicycle_ctrl #(.MEM_HANDSHAKE(HS), .STATE_W(4)) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
      .mem_ready(mem_ready), .pc_write(pc_write), .pc_src(pc_src),
      .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
      .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
      .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .ext_zero(ext_zero), .alu_op(alu_op), .trap(trap), .state(state)
   );

   typedef struct {
      int          st;
      logic [16:0] ctl;
      string       tag;
   } exp_t;

   exp_t sbq[$];
   int   n_vec = 0;
   int   n_bad = 0;

   // Expected control word for one cycle, taken from the per-state output list.
   function automatic logic [16:0] model_ctl(int st, logic rdy, logic z,
                                             logic [5:0] op, logic rst);
      logic pw, iod, mr, mw, irw, rd, m2r, rw, asa, ez, tr, w;
      logic [1:0] ps, asb, aop;
      {pw, iod, mr, mw, irw, rd, m2r, rw, asa, ez, tr} = '0;
      ps = 2'b00; asb = 2'b00; aop = 2'b00;
      w = ((HS != 0) ? rdy : 1'b1) & ~rst;
      case (st)
         0: begin mr = 1'b1; irw = w; pw = w; asb = 2'b01; end
         1: asb = 2'b11;
         2: begin asa = 1'b1; asb = 2'b10; end
         3: begin mr = 1'b1; iod = 1'b1; end
         4: begin rw = 1'b1; m2r = 1'b1; end
         5: begin mw = 1'b1; iod = 1'b1; end
         6: begin asa = 1'b1; aop = 2'b10; end
         7: begin rw = 1'b1; rd = 1'b1; end
         8: begin
            asa = 1'b1; aop = 2'b01; ps = 2'b01;
            pw = ((op == OP_BEQ) && z) || ((op == OP_BNE) && !z);
         end
         9: begin ps = 2'b10; pw = 1'b1; end
         10: begin asa = 1'b1; asb = 2'b10; ez = 1'b1; aop = 2'b11; end
         11: rw = 1'b1;
         12: tr = 1'b1;
         default: ;
      endcase
      return {pw, ps, iod, mr, mw, irw, rd, m2r, rw, asa, asb, ez, aop, tr};
   endfunction

   function automatic logic [5:0] rop();
      return 6'($urandom);
   endfunction

   function automatic logic rb();
      return 1'($urandom);
   endfunction

   // Drive one cycle of inputs and post the outputs expected in that cycle.
   task automatic step(int st, logic [5:0] op, logic rdy, logic z, logic rst,
                       string tag);
      exp_t e;
      opcode    = op;
      mem_ready = rdy;
      zero      = z;
      reset     = rst;
      e.st  = st;
      e.ctl = model_ctl(st, rdy, z, op, rst);
      e.tag = tag;
      sbq.push_back(e);
      @(posedge clk);
      #1;
   endtask

   // One complete instruction: wf fetch stalls, wm memory stalls.
   task automatic run_instr(logic [5:0] op, logic z, int wf, int wm);
      for (int i = 0; i < wf; i++) step(0, rop(), 1'b0, rb(), 1'b0, "fetch_wait");
      step(0, rop(), 1'b1, rb(), 1'b0, "fetch");
      step(1, op, rb(), rb(), 1'b0, "decode");
      case (op)
         OP_LW: begin
            step(2, op, rb(), rb(), 1'b0, "lw_addr");
            for (int i = 0; i < wm; i++) step(3, rop(), 1'b0, rb(), 1'b0, "lw_wait");
            step(3, rop(), 1'b1, rb(), 1'b0, "lw_read");
            step(4, rop(), rb(), rb(), 1'b0, "lw_wb");
         end
         OP_SW: begin
            step(2, op, rb(), rb(), 1'b0, "sw_addr");
            for (int i = 0; i < wm; i++) step(5, rop(), 1'b0, rb(), 1'b0, "sw_wait");
            step(5, rop(), 1'b1, rb(), 1'b0, "sw_write");
         end
         OP_RTYPE: begin
            step(6, rop(), rb(), rb(), 1'b0, "r_exec");
            step(7, rop(), rb(), rb(), 1'b0, "r_wb");
         end
         OP_BEQ, OP_BNE: step(8, op, rb(), z, 1'b0, "branch");
         OP_ORI: begin
            step(10, rop(), rb(), rb(), 1'b0, "ori_exec");
            step(11, rop(), rb(), rb(), 1'b0, "ori_wb");
         end
         OP_J: step(9, rop(), rb(), rb(), 1'b0, "jump");
         default: begin
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
            for (int i = 0; i < 10; i++) step(12, rop(), rb(), rb(), 1'b0, "trap_hold");
            step(12, rop(), rb(), rb(), 1'b1, "trap_reset");
`endif
         end
      endcase
   endtask

   // Monitor: one comparison per falling edge while expectations are queued.
   initial begin
      exp_t        me;
      logic [16:0] act;
      forever begin
         @(negedge clk);
         if (sbq.size() != 0) begin
            me  = sbq.pop_front();
            act = {pc_write, pc_src, i_or_d, mem_read, mem_write, ir_write,
                   reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
                   ext_zero, alu_op, trap};
            n_vec++;
            if ((int'(state) != me.st) || (act !== me.ctl)) begin
               n_bad++;
               $display("FAIL %s: state got %0d want %0d, ctl got %h want %h",
                        me.tag, state, me.st, act, me.ctl);
            end
         end
      end
   end

   logic [5:0] ops[10];

   initial begin
      ops = '{OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ORI, OP_J,
              OP_BAD, 6'b001000, 6'b000001};
      reset = 1'b1; opcode = 6'd0; zero = 1'b0; mem_ready = 1'b0;
      @(posedge clk);
      #1;
      // Reset is still high here and mem_ready is high: reset must win.
      step(0, rop(), 1'b1, rb(), 1'b1, "reset_fetch");

      run_instr(OP_LW, 1'b0, 0, 0);
      run_instr(OP_RTYPE, 1'b0, 0, 0);
      run_instr(OP_BEQ, 1'b1, 0, 0);
      run_instr(OP_BEQ, 1'b0, 0, 0);
      run_instr(OP_BNE, 1'b0, 0, 0);
      run_instr(OP_BNE, 1'b1, 0, 0);
      run_instr(OP_SW, 1'b0, 0, 3);
      run_instr(OP_ORI, 1'b0, 0, 0);
      run_instr(OP_J, 1'b0, 0, 0);
      run_instr(OP_LW, 1'b0, 2, 2);

      // Reset during MEM_READ with mem_ready high aborts the load.
      step(0, rop(), 1'b1, rb(), 1'b0, "fetch");
      step(1, OP_LW, rb(), rb(), 1'b0, "decode");
      step(2, OP_LW, rb(), rb(), 1'b0, "lw_addr");
      step(3, rop(), 1'b0, rb(), 1'b0, "lw_wait");
      step(3, rop(), 1'b1, rb(), 1'b1, "lw_read_reset");
      run_instr(OP_RTYPE, 1'b0, 0, 0);

      run_instr(OP_BAD, 1'b0, 0, 0);
      run_instr(OP_ORI, 1'b0, 1, 0);

      for (int k = 0; k < 40; k++) begin
         run_instr(ops[$urandom_range(0, 9)], rb(), $urandom_range(0, 2),
                   $urandom_range(0, 3));
      end

      repeat (2) @(posedge clk);
      if (sbq.size() != 0) begin
         n_bad++;
         $display("FAIL drain: queued %0d want 0", sbq.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
